// File: rtl/reg_bank_rd_if.sv
// reg_bank_rd_if: write port, read request and read response bundle of the register bank
interface reg_bank_rd_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              req_vld;
   logic              req_rdy;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_vld;
   logic              rsp_rdy;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic [CNT_W-1:0]  rd_cnt;
   modport master (
      output wr_en, wr_addr, wr_data, req_vld, req_addr, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_data, rsp_err, rd_cnt
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, req_vld, req_addr, rsp_rdy,
      output req_rdy, rsp_vld, rsp_data, rsp_err, rd_cnt
   );
endinterface

// File: rtl/reg_bank_rd_responder.sv
// reg_bank_rd_responder: register bank with a direct write port and a single-outstanding read responder
module reg_bank_rd_responder #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 12,
   parameter int CNT_W    = 16
) (
   input logic         clk,
   input logic         rst,
   reg_bank_rd_if.slave bus
);
   // INIT keeps req_rdy low for the first edge after reset release
   typedef enum logic [1:0] {INIT, IDLE, LOOKUP, RESP} state_t;
   state_t            state, state_nxt;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] look_data;
   logic              look_err;
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end
   // next-state: one request in flight, lookup takes one cycle, response held until taken
   always_comb begin
      state_nxt = state == INIT   ? IDLE :
                  state == IDLE   ? (bus.req_vld ? LOOKUP : IDLE) :
                  state == LOOKUP ? RESP :
                                    (bus.rsp_rdy ? IDLE : RESP);
   end
   // handshake outputs decoded from state
   always_comb begin
      bus.req_rdy = state == IDLE;
      bus.rsp_vld = state == RESP;
   end
   // register bank writes; unmapped addresses match no register and are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) regs[i] <= bus.wr_data;
      end
   end
   // latch the read address on request handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             addr <= '0;
      else if (state == IDLE && bus.req_vld) addr <= bus.req_addr;
   end
   // lookup mux with same-cycle write bypass; unmapped addresses read as zero
   always_comb begin
      look_err  = int'(addr) >= NUM_REGS;
      look_data = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (addr == ADDR_W'(i)) look_data = regs[i];
      if (bus.wr_en && bus.wr_addr == addr && !look_err) look_data = bus.wr_data;
   end
   // capture the response once in LOOKUP so later writes cannot disturb it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rsp_data <= '0;
         bus.rsp_err  <= 1'b0;
      end else if (state == LOOKUP) begin
         bus.rsp_data <= look_data;
         bus.rsp_err  <= look_err;
      end
   end
   // count completed response handshakes, wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             bus.rd_cnt <= '0;
      else if (state == RESP && bus.rsp_rdy) bus.rd_cnt <= bus.rd_cnt + CNT_W'(1);
   end
endmodule
